// File: rtl/result_collector_pkg.sv
// Shared configuration for the accelerator result path: array geometry,
// element width, collector FIFO depth and the collector frame-state type.
package Config;

  localparam int sys_cols        = 3;
  localparam int P_BITWIDTH      = 32;
  localparam int COLLECTOR_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } collector_state_e;

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] result_row_t;

endpackage

// File: rtl/result_collector_fifo.sv
// row_fifo: single-clock FIFO holding whole result rows, head visible
// combinationally; full/empty come from an extra wrap bit on each pointer.
module row_fifo
  import Config::*;
#(
  parameter int COLS  = sys_cols,
  parameter int P_W   = P_BITWIDTH,
  parameter int DEPTH = COLLECTOR_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [COLS-1:0][P_W-1:0]  row_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [COLS-1:0][P_W-1:0]  head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [COLS-1:0][P_W-1:0] row_t;

  row_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot that a push into a full FIFO needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= row_i;
  end

endmodule

// File: rtl/result_collector.sv
// result_collector: captures result rows into row_fifo and streams them out one
// element per cycle. Define RESULT_COLLECTOR_RELU_EN to clamp negative elements to 0.
module result_collector
  import Config::*;
#(
  parameter int COLS   = sys_cols,
  parameter int P_W    = P_BITWIDTH,
  parameter int DEPTH  = COLLECTOR_DEPTH,
  parameter int ROWS_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS_W-1:0]    cfg_rows,
  input  logic                 in_valid,
  input  logic [COLS*P_W-1:0]  in_result,
  output logic [P_W-1:0]       out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last_col,
  output logic                 out_last_row,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef logic [COLS-1:0][P_W-1:0] row_t;

  collector_state_e     state_q, state_d;
  logic [ROWS_W-1:0]    rows_left_in_q, rows_left_in_d;
  logic [ROWS_W-1:0]    rows_left_out_q, rows_left_out_d;
  logic [CW-1:0]        col_idx_q, col_idx_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  row_t                 in_row, head_row;
  logic                 fifo_full, fifo_empty;
  logic                 handshake, at_last_col, capture, push, pop, drop, last_hs;
  logic [ROWS_W-1:0]    start_rows;
  logic [P_W-1:0]       head_elem, out_elem;

  assign in_row = in_result;

  row_fifo #(
    .COLS  (COLS),
    .P_W   (P_W),
    .DEPTH (DEPTH)
  ) u_row_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .row_i   (in_row),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_row)
  );

  assign start_rows  = (cfg_rows == '0) ? ROWS_W'(1) : cfg_rows;
  assign handshake   = out_valid && out_ready;
  assign at_last_col = (col_idx_q == LAST_COL);
  assign pop         = handshake && at_last_col;
  assign capture     = in_valid && (state_q == RUN) && (rows_left_in_q != '0);
  // Dropped rows still count against both row budgets so the frame always ends.
  assign push        = capture && (!fifo_full || pop);
  assign drop        = capture && fifo_full && !pop;
  assign last_hs     = handshake && out_last_col && out_last_row;

  always_comb begin
    state_d         = state_q;
    rows_left_in_d  = rows_left_in_q;
    rows_left_out_d = rows_left_out_q - ROWS_W'(pop) - ROWS_W'(drop);
    col_idx_d       = col_idx_q;
    overflow_d      = overflow_q | drop;
    done_d          = 1'b0;

    if (handshake) col_idx_d = at_last_col ? '0 : col_idx_q + CW'(1);
    if (capture)   rows_left_in_d = rows_left_in_q - ROWS_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d         = RUN;
          rows_left_in_d  = start_rows;
          rows_left_out_d = start_rows;
        end
      end
      // Leave RUN on the capturing edge so a one-row frame's final handshake lands in FLUSH.
      RUN: begin
        if (rows_left_in_d == '0) state_d = FLUSH;
      end
      FLUSH: begin
        if (last_hs || (fifo_empty && rows_left_out_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      rows_left_in_q  <= '0;
      rows_left_out_q <= '0;
      col_idx_q       <= '0;
      overflow_q      <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rows_left_in_q  <= rows_left_in_d;
      rows_left_out_q <= rows_left_out_d;
      col_idx_q       <= col_idx_d;
      overflow_q      <= overflow_d;
      done_q          <= done_d;
    end
  end

  assign head_elem = head_row[col_idx_q];

`ifdef RESULT_COLLECTOR_RELU_EN
  assign out_elem = head_elem[P_W-1] ? '0 : head_elem;
`else
  assign out_elem = head_elem;
`endif

  assign out_valid    = !fifo_empty;
  assign out_data     = out_valid ? out_elem : '0;
  assign out_last_col = out_valid && at_last_col;
  assign out_last_row = out_valid && (rows_left_out_q == ROWS_W'(1));
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector; each scenario task drives
// its own stimulus and compares against hand-derived values at the falling edge.
module tb_result_collector;

  localparam int COLS   = 3;
  localparam int P_W    = 32;
  localparam int ROWS_W = 8;

  logic                clk;
  logic                rst;
  logic                start;
  logic [ROWS_W-1:0]   cfg_rows;
  logic                in_valid;
  logic [COLS*P_W-1:0] in_result;
  logic [P_W-1:0]      out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last_col;
  logic                out_last_row;
  logic                busy;
  logic                done;
  logic                overflow;

  int nCompared;
  int nMismatched;

  result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_rows     (cfg_rows),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last_col (out_last_col),
    .out_last_row (out_last_row),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [COLS*P_W-1:0] mkrow(input logic [P_W-1:0] a,
                                                input logic [P_W-1:0] b,
                                                input logic [P_W-1:0] c);
    return {c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_rows = '0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
    nCompared++; if (out_data !== '0) begin nMismatched++; $display("[TB] FAIL reset out_data: got %0d want 0", out_data); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset done: got %b want 0", done); end
    nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset overflow: got %b want 0", overflow); end
    nCompared++; if ({out_last_col, out_last_row} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset last flags: got %b want 00", {out_last_col, out_last_row}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [P_W-1:0] exp;
    out_ready = 1'b1; start = 1'b1; cfg_rows = 8'd2;
    tick();
    start = 1'b0;
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic busy: got %b want 1", busy); end
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic early valid: got %b want 0", out_valid); end
    in_valid = 1'b1; in_result = mkrow(1, 2, 3);
    tick();
    in_result = mkrow(4, 5, 6);
    for (int i = 0; i < 6; i++) begin
      exp = P_W'(i + 1);
      nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic valid[%0d]: got %b want 1", i, out_valid); end
      nCompared++; if (out_data !== exp) begin nMismatched++; $display("[TB] FAIL basic data[%0d]: got %0d want %0d", i, out_data, exp); end
      nCompared++; if (out_last_col !== (i % 3 == 2)) begin nMismatched++; $display("[TB] FAIL basic last_col[%0d]: got %b want %b", i, out_last_col, (i % 3 == 2)); end
      nCompared++; if (out_last_row !== (i >= 3)) begin nMismatched++; $display("[TB] FAIL basic last_row[%0d]: got %b want %b", i, out_last_row, (i >= 3)); end
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic early done[%0d]: got %b want 0", i, done); end
      tick();
      in_valid = 1'b0;
    end
    nCompared++; if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic done: got %b want 1", done); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic busy after: got %b want 0", busy); end
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic valid after: got %b want 0", out_valid); end
    tick();
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic done width: got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    out_ready = 1'b0; start = 1'b1; cfg_rows = 8'd2;
    tick();
    start = 1'b0; in_valid = 1'b1; in_result = mkrow(1, 2, 3);
    tick();
    in_result = mkrow(4, 5, 6);
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 40) begin
      out_ready = (cyc % 2 == 0);
      nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp valid[c%0d]: got %b want 1", cyc, out_valid); end
      nCompared++; if (out_data !== P_W'(idx + 1)) begin nMismatched++; $display("[TB] FAIL bp data[c%0d]: got %0d want %0d", cyc, out_data, idx + 1); end
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp early done[c%0d]: got %b want 0", cyc, done); end
      tick();
      in_valid = 1'b0;
      if (out_ready) idx++;
      cyc++;
    end
    nCompared++; if (idx != 6) begin nMismatched++; $display("[TB] FAIL bp timeout: got %0d elements want 6", idx); end
    nCompared++; if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp done: got %b want 1", done); end
    out_ready = 1'b1;
    tick();
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp busy after: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    int row;
    int col;
    out_ready = 1'b0; start = 1'b1; cfg_rows = 8'd6;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      in_valid = 1'b1; in_result = mkrow(P_W'(10*r + 1), P_W'(10*r + 2), P_W'(10*r + 3));
      tick();
      nCompared++; if (overflow !== (r >= 5)) begin nMismatched++; $display("[TB] FAIL ovf flag[r%0d]: got %b want %b", r, overflow, (r >= 5)); end
    end
    in_valid = 1'b0;
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf busy: got %b want 1", busy); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      row = i / 3 + 1; col = i % 3;
      nCompared++; if (out_data !== P_W'(10*row + col + 1)) begin nMismatched++; $display("[TB] FAIL ovf data[%0d]: got %0d want %0d", i, out_data, 10*row + col + 1); end
      nCompared++; if (out_last_row !== (row == 4)) begin nMismatched++; $display("[TB] FAIL ovf last_row[%0d]: got %b want %b", i, out_last_row, (row == 4)); end
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf early done[%0d]: got %b want 0", i, done); end
      tick();
    end
    nCompared++; if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf done: got %b want 1", done); end
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf drained: got %b want 0", out_valid); end
    nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf sticky: got %b want 1", overflow); end
    do_reset();
    nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf cleared: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; start = 1'b1; cfg_rows = 8'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; in_result = mkrow(1, 2, 3);
    tick();
    in_valid = 1'b0;
    nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid pre valid: got %b want 1", out_valid); end
    rst = 1'b0;
    tick();
    nCompared++; if ({out_valid, busy, done, out_last_col, out_last_row} !== 5'b0) begin nMismatched++; $display("[TB] FAIL rmid flags: got %b want 00000", {out_valid, busy, done, out_last_col, out_last_row}); end
    nCompared++; if (out_data !== '0) begin nMismatched++; $display("[TB] FAIL rmid data: got %0d want 0", out_data); end
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++; if ({done, out_valid} !== 2'b00) begin nMismatched++; $display("[TB] FAIL rmid quiet[%0d]: got %b want 00", i, {done, out_valid}); end
    end
    start = 1'b1; cfg_rows = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_result = mkrow(7, 8, 9);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nCompared++; if (out_data !== P_W'(7 + i)) begin nMismatched++; $display("[TB] FAIL rmid data[%0d]: got %0d want %0d", i, out_data, 7 + i); end
      nCompared++; if (out_last_row !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid last_row[%0d]: got %b want 1", i, out_last_row); end
      tick();
    end
    nCompared++; if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_idle_ignored();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = mkrow(P_W'(90 + i), 0, 0);
      tick();
      nCompared++; if ({out_valid, busy} !== 2'b00) begin nMismatched++; $display("[TB] FAIL idle[%0d]: got %b want 00", i, {out_valid, busy}); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_cfg_zero();
    out_ready = 1'b1; start = 1'b1; cfg_rows = 8'd0;
    tick();
    start = 1'b0; in_valid = 1'b1; in_result = mkrow(11, 12, 13);
    tick();
    in_result = mkrow(14, 15, 16);
    for (int i = 0; i < 3; i++) begin
      nCompared++; if (out_data !== P_W'(11 + i)) begin nMismatched++; $display("[TB] FAIL zero data[%0d]: got %0d want %0d", i, out_data, 11 + i); end
      nCompared++; if (out_last_row !== 1'b1) begin nMismatched++; $display("[TB] FAIL zero last_row[%0d]: got %b want 1", i, out_last_row); end
      tick();
      in_valid = 1'b0;
    end
    nCompared++; if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL zero done: got %b want 1", done); end
    tick();
    nCompared++; if ({out_valid, busy} !== 2'b00) begin nMismatched++; $display("[TB] FAIL zero extra row: got %b want 00", {out_valid, busy}); end
  endtask

  task automatic test_relu();
    logic [P_W-1:0] exp [3];
`ifdef RESULT_COLLECTOR_RELU_EN
    exp[0] = '0;
`else
    exp[0] = 32'hFFFF_FFFB;
`endif
    exp[1] = '0;
    exp[2] = 32'd7;
    out_ready = 1'b1; start = 1'b1; cfg_rows = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_result = mkrow(32'hFFFF_FFFB, 0, 7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nCompared++; if (out_data !== exp[i]) begin nMismatched++; $display("[TB] FAIL relu data[%0d]: got %0h want %0h", i, out_data, exp[i]); end
      tick();
    end
    nCompared++; if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL relu done: got %b want 1", done); end
    tick();
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    clk = 1'b0; rst = 1'b0; start = 1'b0; cfg_rows = '0;
    in_valid = 1'b0; in_result = '0; out_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_idle_ignored();
    test_cfg_zero();
    test_relu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
